// File: rtl/sw_btn_reader.sv
// rtl/sw_btn_reader.sv - switch/button input controller: sync, debounce, sticky button events, read decode
// Optional build macro SW_BTN_IRQ_EN: when defined, irq is asserted while any button event is pending.
module sw_btn_reader #(
    parameter int DB_CNT = 100000,
    parameter int CNT_W  = 17
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] sw,
    input  logic [4:0]  btn,
    input  logic        en,
    input  logic        sw_ctrl,
    input  logic        btn_ctrl,
    output logic [31:0] read_data,
    output logic        irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CNT - 1);

    // All 21 inputs are handled as one vector: buttons in [20:16], switches in [15:0].
    logic [20:0]      r_sync1;
    logic [20:0]      r_sync2;
    logic [20:0]      r_hist0;
    logic [20:0]      r_hist1;
    logic [20:0]      r_db;
    logic [4:0]       r_btn_event;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_read_data;

    logic             w_tick;
    logic [20:0]      w_agree;
    logic [20:0]      w_db_next;
    logic [4:0]       w_btn_rise;
    logic             w_rd_sw;
    logic             w_rd_btn;

    assign w_tick = (r_cnt == CNT_MAX);

    // A bit settles only when the current sample matches both previous samples.
    assign w_agree    = ~(r_sync2 ^ r_hist0) & ~(r_sync2 ^ r_hist1);
    assign w_db_next  = (w_agree & r_sync2) | (~w_agree & r_db);
    assign w_btn_rise = {5{w_tick}} & w_db_next[20:16] & ~r_db[20:16];

    // Switch select takes priority, so a combined select never clears events.
    assign w_rd_sw  = en & sw_ctrl;
    assign w_rd_btn = en & ~sw_ctrl & btn_ctrl;

    // Two-flop synchronizer for every raw input.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {btn, sw};
            r_sync2 <= r_sync1;
        end
    end

    // Free-running prescaler that produces one debounce tick per period.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Sample history and debounced levels advance only on the tick.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hist0 <= '0;
            r_hist1 <= '0;
            r_db    <= '0;
        end else if (w_tick) begin
            r_hist0 <= r_sync2;
            r_hist1 <= r_hist0;
            r_db    <= w_db_next;
        end
    end

    // Sticky press events; a rise on the clearing edge survives the clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_btn_event <= '0;
        end else begin
            r_btn_event <= (w_rd_btn ? 5'b0 : r_btn_event) | w_btn_rise;
        end
    end

    // Registered read port; holds its value between strobes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_read_data <= '0;
        end else if (en) begin
            if (w_rd_sw) begin
                r_read_data <= {16'b0, r_db[15:0]};
            end else if (w_rd_btn) begin
                r_read_data <= {19'b0, r_btn_event, 3'b0, r_db[20:16]};
            end else begin
                r_read_data <= '0;
            end
        end
    end

    assign read_data = r_read_data;

`ifdef SW_BTN_IRQ_EN
    logic r_irq;

    // Interrupt follows the pending-event vector one cycle later.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |r_btn_event;
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_sw_btn_reader.sv
// tb/tb_sw_btn_reader.sv - directed self-checking bench for sw_btn_reader (DB_CNT=4)
`timescale 1ns/1ps
module tb_sw_btn_reader;

    logic        clk;
    logic        rstn;
    logic [15:0] sw;
    logic [4:0]  btn;
    logic        en;
    logic        sw_ctrl;
    logic        btn_ctrl;
    logic [31:0] read_data;
    logic        irq;

    int checks;
    int errors;
    int cyc;

`ifdef SW_BTN_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    sw_btn_reader #(.DB_CNT(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .sw        (sw),
        .btn       (btn),
        .en        (en),
        .sw_ctrl   (sw_ctrl),
        .btn_ctrl  (btn_ctrl),
        .read_data (read_data),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench cycle index: after the n-th posedge following reset release, cyc == n.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_read(input logic s, input logic b);
        en       = 1'b1;
        sw_ctrl  = s;
        btn_ctrl = b;
        step();
        en       = 1'b0;
        sw_ctrl  = 1'b0;
        btn_ctrl = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rstn     = 1'b0;
        sw       = 16'hFFFF;
        btn      = 5'h1F;
        en       = 1'b0;
        sw_ctrl  = 1'b0;
        btn_ctrl = 1'b0;

        // Reset held with all inputs high.
        repeat (3) step();
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_db", {11'b0, dut.r_db}, 32'h0);
        chk("rst_event", {27'b0, dut.r_btn_event}, 32'h0);
        chk("rst_cnt", {29'b0, dut.r_cnt}, 32'h0);

        // Release reset; inputs still high but not yet debounced.
        rstn = 1'b1;
        repeat (3) step();
        do_read(1'b1, 1'b0);
        chk("post_rst_sw_read", read_data, 32'h0);

        // Buttons held through reset produce a fresh event at cycle 12.
        wait_cyc(15);
        chk("held_irq_set", {31'b0, irq}, {31'b0, IRQ_ON});
        do_read(1'b0, 1'b1);
        chk("held_btn_read", read_data, 32'h00001F1F);
        step();
        chk("held_irq_clr", {31'b0, irq}, 32'h0);

        // Switch debounce of a stable pattern; button release sets no event.
        sw  = 16'hA5C3;
        btn = 5'h00;
        wait_cyc(36);
        do_read(1'b1, 1'b0);
        chk("sw_stable", read_data, 32'h0000A5C3);
        step();
        do_read(1'b0, 1'b1);
        chk("btn_all_released", read_data, 32'h0);
        chk("irq_idle", {31'b0, irq}, 32'h0);

        // Five-cycle glitch on sw[0] must be rejected.
        wait_cyc(40);
        sw = 16'hA5C2;
        repeat (5) step();
        sw = 16'hA5C3;
        wait_cyc(50);
        do_read(1'b1, 1'b0);
        chk("glitch_mid", read_data, 32'h0000A5C3);
        wait_cyc(60);
        do_read(1'b1, 1'b0);
        chk("glitch_after", read_data, 32'h0000A5C3);

        // Press btn[2]: db rises at cycle 76.
        wait_cyc(64);
        btn = 5'b00100;
        wait_cyc(80);
        chk("btn2_irq_set", {31'b0, irq}, {31'b0, IRQ_ON});
        do_read(1'b0, 1'b1);
        chk("btn2_first_read", read_data, 32'h00000404);
        chk("btn2_irq_hold", {31'b0, irq}, {31'b0, IRQ_ON});
        do_read(1'b0, 1'b1);
        chk("btn2_second_read", read_data, 32'h00000004);
        chk("btn2_irq_clr", {31'b0, irq}, 32'h0);

        // Release btn[2]: db falls at cycle 96, no event.
        wait_cyc(84);
        btn = 5'b00000;
        wait_cyc(100);
        do_read(1'b0, 1'b1);
        chk("btn2_release", read_data, 32'h0);
        do_read(1'b0, 1'b1);
        chk("btn2_no_event", read_data, 32'h0);

        // Press btn[0] at cycle 104; its db rises on posedge 116, same edge as the read.
        wait_cyc(104);
        btn = 5'b00001;
        wait_cyc(115);
        do_read(1'b0, 1'b1);
        chk("clr_rise_same_edge", read_data, 32'h0);
        do_read(1'b0, 1'b1);
        chk("clr_rise_next", read_data, 32'h00000101);

        // Press btn[1]; combined select returns switches and keeps the event.
        wait_cyc(120);
        btn = 5'b00011;
        wait_cyc(136);
        do_read(1'b1, 1'b1);
        chk("prio_sw_wins", read_data, 32'h0000A5C3);
        chk("prio_irq_pending", {31'b0, irq}, {31'b0, IRQ_ON});
        do_read(1'b0, 1'b1);
        chk("prio_event_kept", read_data, 32'h00000203);
        step();
        chk("prio_irq_clr", {31'b0, irq}, 32'h0);

        // read_data holds with en low; a strobe with no select returns zero.
        repeat (2) step();
        chk("hold_no_en", read_data, 32'h00000203);
        do_read(1'b0, 1'b0);
        chk("no_select", read_data, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
